// File: rtl/sb_bus_pkg.sv
// Shared constants for the system-bus decoder: response codes, burst size codes,
// FSM encodings and the size-to-beat-count helper.
package sb_bus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SZ_SINGLE0 = 3'b000;
  localparam logic [2:0] SZ_SINGLE1 = 3'b001;
  localparam logic [2:0] SZ_SINGLE2 = 3'b010;
  localparam logic [2:0] SZ_BURST2  = 3'b011;
  localparam logic [2:0] SZ_BURST4  = 3'b100;
  localparam logic [2:0] SZ_BURST8  = 3'b101;
  localparam logic [2:0] SZ_BURST16 = 3'b110;
  localparam logic [2:0] SZ_BURST32 = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Beats in the burst minus one; the three single-beat codes collapse to 0.
  function automatic logic [4:0] size_to_bm1(input logic [2:0] sz);
    logic [4:0] bm1;
    case (sz)
      SZ_BURST2:  bm1 = 5'd1;
      SZ_BURST4:  bm1 = 5'd3;
      SZ_BURST8:  bm1 = 5'd7;
      SZ_BURST16: bm1 = 5'd15;
      SZ_BURST32: bm1 = 5'd31;
      default:    bm1 = 5'd0;
    endcase
    return bm1;
  endfunction

endpackage

// File: rtl/sb_decoder_nslave_if.sv
// Master-side request/beat signals and decoder-side select/response signals.
interface sb_decoder_nslave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_SLAVES   = 3,
  parameter int ERRCNT_WIDTH = 8
);
  logic                    sb_req;
  logic                    sb_ready;
  logic [ADDR_WIDTH-1:0]   sb_addr;
  logic [2:0]              sb_size;
  logic                    sb_beat_ack;
  logic [NUM_SLAVES-1:0]   sb_sel;
  logic [1:0]              sb_resp;
  logic                    sb_resp_valid;
  logic                    add_notokay;
  logic [ERRCNT_WIDTH-1:0] sb_err_count;

  modport master (
    output sb_req, sb_addr, sb_size, sb_beat_ack,
    input  sb_ready, sb_sel, sb_resp, sb_resp_valid, add_notokay, sb_err_count
  );

  modport slave (
    input  sb_req, sb_addr, sb_size, sb_beat_ack,
    output sb_ready, sb_sel, sb_resp, sb_resp_valid, add_notokay, sb_err_count
  );
endinterface

// File: rtl/sb_region_check.sv
// Combinational decode of a latched request: region index, beat count and
// whether the whole burst fits inside the addressed slave's window.
module sb_region_check
  import sb_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_BITS   = 2,
  parameter int OFFS_WIDTH = ADDR_WIDTH - SEL_BITS,
  parameter logic [NUM_SLAVES*OFFS_WIDTH-1:0] SLV_LIMITS = {30'd4095, 30'd2047, 30'd2047}
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  output logic [SEL_BITS-1:0]   region,
  output logic [4:0]            bm1,
  output logic                  mapped,
  output logic                  in_range
);
  localparam logic [SEL_BITS-1:0] MAX_REGION = SEL_BITS'(NUM_SLAVES);

  logic [OFFS_WIDTH-1:0] offset;
  logic [OFFS_WIDTH-1:0] limit;
  logic [OFFS_WIDTH:0]   last_offs;

  assign region = addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign offset = addr[OFFS_WIDTH-1:0];
  assign bm1    = size_to_bm1(size);
  assign mapped = (region != '0) && (region <= MAX_REGION);

  always_comb begin
    limit = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (region == SEL_BITS'(i + 1)) limit = SLV_LIMITS[i*OFFS_WIDTH +: OFFS_WIDTH];
  end

  // One extra bit so a burst running off the top of the offset space cannot wrap.
  assign last_offs = {1'b0, offset} + (OFFS_WIDTH+1)'(bm1);
  assign in_range  = last_offs <= {1'b0, limit};

endmodule

// File: rtl/sb_decoder_nslave.sv
// N-slave system-bus address decoder: accepts a request, range-checks it,
// holds the slave select for the whole burst and issues one completion.
module sb_decoder_nslave
  import sb_bus_pkg::*;
#(
  parameter int NUM_SLAVES   = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int SEL_BITS     = 2,
  parameter int OFFS_WIDTH   = ADDR_WIDTH - SEL_BITS,
  parameter logic [NUM_SLAVES*OFFS_WIDTH-1:0] SLV_LIMITS = {30'd4095, 30'd2047, 30'd2047},
  parameter int ERRCNT_WIDTH = 8
) (
  input logic          sb_clk,
  input logic          sb_reset,
  sb_decoder_nslave_if.slave bus
);
  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [1:0]              resp_q, resp_d;
  logic [ERRCNT_WIDTH-1:0] err_q, err_d;

  logic [SEL_BITS-1:0] region;
  logic [4:0]          bm1;
  logic                mapped, in_range;

  sb_region_check #(
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES), .SEL_BITS(SEL_BITS),
    .OFFS_WIDTH(OFFS_WIDTH), .SLV_LIMITS(SLV_LIMITS)
  ) u_check (
    .addr(addr_q), .size(size_q), .region(region), .bm1(bm1),
    .mapped(mapped), .in_range(in_range)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    resp_d  = resp_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (bus.sb_req) begin
        addr_d  = bus.sb_addr;
        size_d  = bus.sb_size;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!mapped) begin
          resp_d  = RESP_DECERR;
          state_d = ST_RESP;
        end else if (!in_range) begin
          resp_d  = RESP_SLVERR;
          state_d = ST_RESP;
        end else begin
          cnt_d   = bm1;
          sel_d   = NUM_SLAVES'(1) << (region - SEL_BITS'(1));
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: if (bus.sb_beat_ack) begin
        if (cnt_q == '0) begin
          sel_d   = '0;
          resp_d  = RESP_OKAY;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_RESP: begin
        // Counter sticks at all-ones rather than wrapping back to zero.
        if (resp_q != RESP_OKAY && err_q != '1) err_d = err_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign bus.sb_ready      = (state_q == ST_IDLE);
  assign bus.sb_sel        = sel_q;
  assign bus.sb_resp       = resp_q;
  assign bus.sb_resp_valid = (state_q == ST_RESP);
  assign bus.add_notokay   = (state_q == ST_RESP) && (resp_q != RESP_OKAY);
  assign bus.sb_err_count  = err_q;

endmodule

// File: doc/sb_decoder_nslave.md
Name: sb_decoder_nslave

Overview:
- Parametrised system-bus address decoder for N slaves, with a request/ready handshake and burst-range checking.
- Selection is held for the whole burst; it is not re-evaluated every cycle.
- Issues an OKAY, SLVERR or DECERR completion response and keeps a saturating error counter.
- Sits between the bus master and the slave select/response mux.

Parameters:
- NUM_SLAVES, 3: number of slave regions; valid range 1..(2^SEL_BITS - 1).
- ADDR_WIDTH, 32: bus address width.
- SEL_BITS, 2: number of top address bits used as the region index.
- OFFS_WIDTH, ADDR_WIDTH-SEL_BITS: offset width within a region.
- SLV_LIMITS, {30'd4095, 30'd2047, 30'd2047}: packed NUM_SLAVES*OFFS_WIDTH bits. Slice i holds the last valid offset of slave i.
- ERRCNT_WIDTH, 8: width of the error counter.

Ports:
- sb_clk  in  1  clock.
- sb_reset  in  1  asynchronous, active-high reset.
- sb_req  in  1  master request valid.
- sb_ready  out  1  decoder can accept a request.
- sb_addr  in  ADDR_WIDTH  start address; sampled on handshake.
- sb_size  in  3  burst size code; sampled on handshake.
- sb_beat_ack  in  1  selected slave accepted one beat.
- sb_sel  out  NUM_SLAVES  one-hot slave select.
- sb_resp  out  2  completion code: 00 OKAY, 10 SLVERR, 11 DECERR.
- sb_resp_valid  out  1  one-cycle pulse qualifying sb_resp.
- add_notokay  out  1  one-cycle pulse on an SLVERR or DECERR completion.
- sb_err_count  out  ERRCNT_WIDTH  saturating count of error completions.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - state to IDLE, sb_ready=1;
  - sb_sel=0, sb_resp=00, sb_resp_valid=0, add_notokay=0, sb_err_count=0;
  - internal address, size and beat registers to 0.
- Reset asserted mid-burst drops sb_sel immediately; no response is issued for the aborted burst.
- Handshake: the request is accepted in a cycle where sb_req && sb_ready. sb_addr and sb_size are latched at that edge.
- sb_ready is 1 only in IDLE; sb_req in other states is ignored.
- Beat count minus one (bm1), from sb_size:
  - 000, 001 or 010 -> 0
  - 011 -> 1
  - 100 -> 3
  - 101 -> 7
  - 110 -> 15
  - 111 -> 31
- Region index r = addr[ADDR_WIDTH-1 -: SEL_BITS]. r=0 or r>NUM_SLAVES is unmapped; otherwise the target is slave s=r-1.
- Range check: error if offset + bm1 > SLV_LIMITS[s], computed at OFFS_WIDTH+1 bits so the sum cannot wrap. Equality with the limit is legal.
- States:
  - IDLE: on handshake -> CHECK.
  - CHECK (one cycle): registered decode and range compare.
    - Unmapped -> RESP with DECERR.
    - Out of range -> RESP with SLVERR.
    - Otherwise -> ACTIVE; load beat counter with bm1; set sb_sel[s] at the same edge.
  - ACTIVE: sb_sel held. Each sb_beat_ack decrements the counter. sb_beat_ack with counter==0 clears sb_sel and -> RESP with OKAY.
  - RESP (one cycle): sb_resp_valid=1 and sb_resp valid.
    - add_notokay=1 if the code is not OKAY; sb_err_count increments, saturating at all-ones.
    - Then -> IDLE.
- Latency: handshake in cycle N; CHECK in N+1; sb_sel (or error response) visible from N+2. The fastest return to IDLE is N+3.
- sb_beat_ack outside ACTIVE is ignored.
- sb_resp holds its last value between pulses.
- sb_sel never has more than one bit set.

Decomposition:
- Package sb_bus_pkg holds:
  - response codes RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - sb_size code constants;
  - FSM state encodings (2-bit: IDLE, CHECK, ACTIVE, RESP).
- Sub-module sb_region_check is combinational. Inputs: latched address and size. Outputs: region index, bm1, mapped flag, in_range flag. The top level keeps the FSM, counter and outputs.

Test Plan:
- Reset, then sb_addr=32'h4000_0010, sb_size=3'b100, handshake -> sb_sel=3'b001 at N+2. After 4 sb_beat_ack: sb_sel=0, sb_resp=00 with a one-cycle sb_resp_valid, add_notokay=0.
- sb_addr=32'h8000_07F8, sb_size=3'b110 (offset 2040 + 15 > 2047) -> no select, sb_resp=10, add_notokay pulse, sb_err_count=1.
- Boundary: sb_addr=32'hC000_0FE0, sb_size=3'b111 (offset 4064 + 31 = 4095) -> sb_sel=3'b100, OKAY after 32 beats. Same burst at offset 4065 -> SLVERR.
- sb_addr=32'h0000_0000 -> DECERR (11), sb_sel stays 0. sb_req held high during CHECK/RESP sees sb_ready=0 and is not double-accepted.
- Assert sb_reset after beat 2 of an 8-beat burst to slave 2 -> sb_sel=0 immediately with no response pulse. The next request is accepted normally.
- 260 back-to-back DECERR requests -> sb_err_count saturates at 255 and does not wrap.
